stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Parametrised stage sequencer for the multicycle core: it replaces the fixed five-stage controller with one that walks `NUM_STAGES` stages and waits on a per-stage ready signal, so multi-cycle memories and ALUs can stall a stage. It produces the per-stage pipeline-register write pulses, the PC/RAM/register-file write qualifiers and the stage reset. It also adds halt/resume control and a retired-instruction counter. It sits beside the datapath top and drives every pipeline register's `wren`.

## Interface
Parameters:
- `NUM_STAGES`, 5, number of stages (2..16); stage `NUM_STAGES-1` is write-back.
- `MEM_STAGE`, 3, index of the stage whose completion qualifies `ram_wren`.
- `RESET_HOLD_CYCLES`, 2, clock edges `stage_reset_n` is held low after `reset_n` deasserts (1..15).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stage_ready`  in  `NUM_STAGES`  bit i high: stage i has completed its work this cycle.
- `halt_req`  in  1  request halt at the next instruction boundary.
- `resume_req`  in  1  leave HALTED.
- `stage_wren`  out  `NUM_STAGES`  bit i pulses for one cycle to capture the register following stage i.
- `pc_wren`  out  1  equals `stage_wren[NUM_STAGES-1]`.
- `ram_wren`  out  1  equals `stage_wren[MEM_STAGE]`.
- `reg_wren`  out  1  equals `stage_wren[NUM_STAGES-1]`.
- `stage_reset_n`  out  1  registered; low during reset and the hold window.
- `current_stage`  out  `$clog2(NUM_STAGES)`  active stage index.
- `halted`  out  1  high in HALTED.
- `instret`  out  32  count of completed write-back stages.

## Operation
- States:
  - HOLD: entered on reset. A counter counts `RESET_HOLD_CYCLES` edges, then the block moves to RUN with `current_stage`=0 and `stage_reset_n`=1.
  - RUN: on any cycle with `stage_ready[current_stage]`=1:
    - `stage_wren[current_stage]`=1 combinationally;
    - next edge, `current_stage` increments, wrapping from `NUM_STAGES-1` to 0.
    - With ready low, the stage holds and all wren outputs are 0.
  - HALTED: all wren outputs are 0 and `current_stage`=0. On `resume_req`=1 the block returns to RUN at the next edge.
- Halt:
  - `halt_req` high in any RUN cycle sets `halt_pending`.
  - On write-back completion with `halt_pending` set (or `halt_req` high that cycle), the block enters HALTED and clears `halt_pending`.
  - A halt never interrupts a partially executed instruction.
- Simultaneous events:
  - In HALTED, `resume_req` wins over `halt_req`; `halt_req` is ignored there.
  - `halt_req` and write-back completion in the same cycle halts at that boundary.
- `instret` increments on every write-back completion and wraps from 0xFFFFFFFF to 0.
- At most one `stage_wren` bit is high in any cycle.

## Timing
- Reset values (while `reset_n`=0): `stage_wren`=0, `pc_wren`/`ram_wren`/`reg_wren`=0, `stage_reset_n`=0, `current_stage`=0, `halted`=0, `instret`=0, state HOLD, `halt_pending`=0.
- Reset asserted mid-instruction clears all state immediately; no wren pulse is produced while `reset_n`=0.
- `stage_reset_n` rises at edge `RESET_HOLD_CYCLES` after `reset_n` deassertion. `stage_wren[0]` can first assert in the following cycle.
- With `stage_ready` all ones, one instruction retires every `NUM_STAGES` cycles.
- Each stall cycle adds exactly one cycle of latency.
- `halted` rises at the edge after the halting write-back pulse. The cycle after `resume_req` is sampled, stage 0 is active.

## Configuration
- `STAGE_SEQUENCER_STEP_EN` defined: adds input `step_req` (1 bit).
  - In HALTED, `step_req`=1 runs exactly one instruction from stage 0 through write-back, then returns to HALTED. `instret` increments by 1.
  - `resume_req` takes priority over `step_req`.
  - `step_req` outside HALTED is ignored.
- Undefined: the `step_req` port is absent, and HALTED is left only via `resume_req`.

## Test plan
- Reset release with defaults and `stage_ready`=5'b11111 -> `stage_reset_n` rises at edge 2; `stage_wren` then shows one-hot 00001, 00010, 00100, 01000, 10000 on consecutive cycles. `ram_wren` pulses with bit 3; `pc_wren`/`reg_wren` pulse with bit 4; `instret`=1.
- `stage_ready[3]` low for 4 cycles in stage 3 -> `current_stage` holds at 3 and no wren pulses. The instruction retires at cycle 9 instead of 5.
- `halt_req` pulsed at stage 1 -> the instruction completes its write-back, then `halted`=1 with no further wren. `resume_req` -> stage 0 active on the next cycle.
- Reset asserted during stage 2 -> all outputs zero asynchronously and `instret`=0. Recovery matches the first scenario.
- `NUM_STAGES`=3, `MEM_STAGE`=1, preloaded `instret`=0xFFFFFFFF via forced counter -> the next write-back gives `instret`=0. `ram_wren` coincides with `stage_wren[1]`.
- With `STAGE_SEQUENCER_STEP_EN`: from HALTED, `step_req` -> exactly 5 wren pulses, `instret` +1, back in HALTED. `step_req` and `resume_req` together -> RUN.

Source files
------------

// File: rtl/stage_sequencer.sv
// Stage sequencer: walks NUM_STAGES pipeline stages gated by per-stage ready, with halt/resume
// and a retired-instruction counter. Define STAGE_SEQUENCER_STEP_EN to add single-step from HALTED.
module stage_sequencer #(
   parameter int NUM_STAGES        = 5,
   parameter int MEM_STAGE         = 3,
   parameter int RESET_HOLD_CYCLES = 2,
   localparam int SW               = $clog2(NUM_STAGES)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_STAGES-1:0] stage_ready,
   input  logic                  halt_req,
   input  logic                  resume_req,
`ifdef STAGE_SEQUENCER_STEP_EN
   input  logic                  step_req,
`endif
   output logic [NUM_STAGES-1:0] stage_wren,
   output logic                  pc_wren,
   output logic                  ram_wren,
   output logic                  reg_wren,
   output logic                  stage_reset_n,
   output logic [SW-1:0]         current_stage,
   output logic                  halted,
   output logic [31:0]           instret
);

   // state    | meaning
   // S_HOLD   | stage reset held low while the hold counter runs down
   // S_RUN    | walking stages, each advancing on its ready
   // S_HALTED | parked at stage 0, no write enables
   // S_STEP   | running a single instruction, then back to S_HALTED
   typedef enum logic [1:0] {S_HOLD, S_RUN, S_HALTED, S_STEP} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   cur_q, cur_d;
   logic [3:0]      hold_q, hold_d;
   logic            pend_q, pend_d;
   logic [31:0]     instret_q, instret_d;
   logic            srn_q, srn_d;
   logic            stage_done;
   logic            last_stage;

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      hold_d     = hold_q;
      pend_d     = pend_q;
      instret_d  = instret_q;
      stage_wren = '0;
      stage_done = stage_ready[cur_q];
      last_stage = (cur_q == SW'(NUM_STAGES - 1));

      case (state_q)
         S_HOLD: begin
            cur_d = '0;
            if (hold_q <= 4'd1) begin
               state_d = S_RUN;
            end else begin
               hold_d = hold_q - 4'd1;
            end
         end
         S_RUN, S_STEP: begin
            if (state_q == S_RUN && halt_req) begin
               pend_d = 1'b1;
            end
            if (stage_done) begin
               stage_wren = NUM_STAGES'(1) << cur_q;
               if (last_stage) begin
                  cur_d     = '0;
                  instret_d = instret_q + 32'd1;
                  // Instruction boundary: the only point where a halt may take effect.
                  if (state_q == S_STEP || pend_q || halt_req) begin
                     state_d = S_HALTED;
                     pend_d  = 1'b0;
                  end
               end else begin
                  cur_d = cur_q + SW'(1);
               end
            end
         end
         S_HALTED: begin
            cur_d = '0;
            if (resume_req) begin
               state_d = S_RUN;
            end
`ifdef STAGE_SEQUENCER_STEP_EN
            else if (step_req) begin
               state_d = S_STEP;
            end
`endif
         end
         default: begin
            state_d = S_HOLD;
            cur_d   = '0;
         end
      endcase

      srn_d = (state_d != S_HOLD);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_HOLD;
         cur_q     <= '0;
         hold_q    <= 4'(RESET_HOLD_CYCLES);
         pend_q    <= 1'b0;
         instret_q <= '0;
         srn_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         hold_q    <= hold_d;
         pend_q    <= pend_d;
         instret_q <= instret_d;
         srn_q     <= srn_d;
      end
   end

   assign pc_wren       = stage_wren[NUM_STAGES-1];
   assign reg_wren      = stage_wren[NUM_STAGES-1];
   assign ram_wren      = stage_wren[MEM_STAGE];
   assign stage_reset_n = srn_q;
   assign current_stage = cur_q;
   assign halted        = (state_q == S_HALTED);
   assign instret       = instret_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a 5-stage default instance and a 3-stage instance
// for counter wrap; single-step checks are built only with STAGE_SEQUENCER_STEP_EN.
module tb_stage_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [4:0]  ready5;
   logic        halt_req, resume_req;
   logic [2:0]  ready3;
   logic        halt3, resume3;
`ifdef STAGE_SEQUENCER_STEP_EN
   logic        step_req, step3;
`endif

   logic [4:0]  wren5;
   logic        pc5, ram5, reg5, srn5, halted5;
   logic [2:0]  cur5;
   logic [31:0] instret5;
   logic [2:0]  wren3;
   logic        pc3, ram3, reg3, srn3, halted3;
   logic [1:0]  cur3;
   logic [31:0] instret3;

   int n_tests = 0;
   int n_fail  = 0;
   int found;
   int pulses;

   stage_sequencer dut5 (
      .clk(clk), .reset_n(reset_n), .stage_ready(ready5),
      .halt_req(halt_req), .resume_req(resume_req),
`ifdef STAGE_SEQUENCER_STEP_EN
      .step_req(step_req),
`endif
      .stage_wren(wren5), .pc_wren(pc5), .ram_wren(ram5), .reg_wren(reg5),
      .stage_reset_n(srn5), .current_stage(cur5), .halted(halted5), .instret(instret5)
   );

   stage_sequencer #(.NUM_STAGES(3), .MEM_STAGE(1)) dut3 (
      .clk(clk), .reset_n(reset_n), .stage_ready(ready3),
      .halt_req(halt3), .resume_req(resume3),
`ifdef STAGE_SEQUENCER_STEP_EN
      .step_req(step3),
`endif
      .stage_wren(wren3), .pc_wren(pc3), .ram_wren(ram3), .reg_wren(reg3),
      .stage_reset_n(srn3), .current_stage(cur3), .halted(halted3), .instret(instret3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Releases reset and walks the first instruction with all stages ready.
   task automatic release_and_run(input string tag);
      repeat (2) cyc();
      reset_n = 1'b1;
      cyc(); #1;
      chk({tag, "_srn_edge1"}, 32'(srn5), 32'd0);
      cyc(); #1;
      chk({tag, "_srn_edge2"}, 32'(srn5), 32'd1);
      chk({tag, "_wren_s0"}, 32'(wren5), 32'h01);
      chk({tag, "_cur_s0"}, 32'(cur5), 32'd0);
      for (int i = 1; i < 5; i++) begin
         cyc(); #1;
         chk($sformatf("%s_wren_s%0d", tag, i), 32'(wren5), 32'd1 << i);
         chk($sformatf("%s_ram_s%0d", tag, i), 32'(ram5), 32'(i == 3));
         chk($sformatf("%s_pc_s%0d", tag, i), 32'(pc5), 32'(i == 4));
         chk($sformatf("%s_reg_s%0d", tag, i), 32'(reg5), 32'(i == 4));
      end
      cyc(); #1;
      chk({tag, "_instret"}, instret5, 32'd1);
      chk({tag, "_wren_next"}, 32'(wren5), 32'h01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; ready5 = '1; ready3 = '1;
      halt_req = 1'b0; resume_req = 1'b0; halt3 = 1'b0; resume3 = 1'b0;
`ifdef STAGE_SEQUENCER_STEP_EN
      step_req = 1'b0; step3 = 1'b0;
`endif
      #2;
      cyc(); cyc(); #1;
      chk("rst_wren", 32'(wren5), 32'd0);
      chk("rst_pc", 32'(pc5), 32'd0);
      chk("rst_ram", 32'(ram5), 32'd0);
      chk("rst_reg", 32'(reg5), 32'd0);
      chk("rst_srn", 32'(srn5), 32'd0);
      chk("rst_cur", 32'(cur5), 32'd0);
      chk("rst_halted", 32'(halted5), 32'd0);
      chk("rst_instret", instret5, 32'd0);

      release_and_run("r1");

      // Stall stage 3 for four full cycles
      cyc();
      cyc(); ready5 = 5'b10111; #1;
      chk("stall_s2_wren", 32'(wren5), 32'h04);
      for (int k = 0; k < 4; k++) begin
         cyc(); #1;
         chk($sformatf("stall_cur_%0d", k), 32'(cur5), 32'd3);
         chk($sformatf("stall_wren_%0d", k), 32'(wren5), 32'd0);
      end
      cyc(); ready5 = '1; #1;
      chk("stall_release_wren", 32'(wren5), 32'h08);
      cyc(); #1;
      chk("stall_wb_wren", 32'(wren5), 32'h10);
      cyc(); #1;
      chk("stall_instret", instret5, 32'd2);
      chk("stall_next_s0", 32'(wren5), 32'h01);

      // Halt requested mid-instruction
      cyc(); halt_req = 1'b1; #1;
      chk("halt_s1_wren", 32'(wren5), 32'h02);
      cyc(); halt_req = 1'b0; #1;
      chk("halt_cur2", 32'(cur5), 32'd2);
      cyc(); cyc(); #1;
      chk("halt_wb_wren", 32'(wren5), 32'h10);
      chk("halt_wb_not_halted", 32'(halted5), 32'd0);
      cyc(); #1;
      chk("halted", 32'(halted5), 32'd1);
      chk("halted_wren", 32'(wren5), 32'd0);
      chk("halted_cur", 32'(cur5), 32'd0);
      chk("halted_instret", instret5, 32'd3);
      cyc(); halt_req = 1'b1; #1;
      chk("halted_ignore_halt", 32'(halted5), 32'd1);
      cyc(); resume_req = 1'b1; #1;
      chk("halted_before_resume", 32'(wren5), 32'd0);
      cyc(); halt_req = 1'b0; resume_req = 1'b0; #1;
      chk("resume_halted", 32'(halted5), 32'd0);
      chk("resume_wren", 32'(wren5), 32'h01);
      chk("resume_cur", 32'(cur5), 32'd0);
      repeat (4) cyc(); #1;
      chk("resume_wb", 32'(wren5), 32'h10);
      cyc(); #1;
      chk("no_stale_pending", 32'(halted5), 32'd0);
      chk("resume_instret", instret5, 32'd4);

      // Halt request on the write-back cycle itself
      repeat (4) cyc();
      halt_req = 1'b1; #1;
      chk("halt_at_wb_wren", 32'(wren5), 32'h10);
      cyc(); halt_req = 1'b0; #1;
      chk("halt_at_wb_halted", 32'(halted5), 32'd1);
      chk("halt_at_wb_instret", instret5, 32'd5);
      chk("halt_at_wb_wren0", 32'(wren5), 32'd0);
      cyc(); resume_req = 1'b1;
      cyc(); resume_req = 1'b0; #1;
      chk("resume2_wren", 32'(wren5), 32'h01);

      // Asynchronous reset during stage 2
      cyc(); cyc(); #1;
      chk("pre_reset_cur", 32'(cur5), 32'd2);
      reset_n = 1'b0; #1;
      chk("async_rst_wren", 32'(wren5), 32'd0);
      chk("async_rst_pc", 32'(pc5), 32'd0);
      chk("async_rst_srn", 32'(srn5), 32'd0);
      chk("async_rst_cur", 32'(cur5), 32'd0);
      chk("async_rst_instret", instret5, 32'd0);
      chk("async_rst_halted", 32'(halted5), 32'd0);
      release_and_run("r2");

      // 3-stage instance: counter wrap and ram_wren on stage 1
      found = 0;
      for (int k = 0; k < 4 && found == 0; k++) begin
         if (cur3 == 2'd0 && wren3 == 3'b001) found = 1;
         else begin cyc(); #1; end
      end
      chk("wrap_find_s0", 32'(found), 32'd1);
      force dut3.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut3.instret_q;
      #1;
      chk("wrap_preload", instret3, 32'hFFFF_FFFF);
      cyc(); #1;
      chk("wrap3_wren_s1", 32'(wren3), 32'h2);
      chk("wrap3_ram", 32'(ram3), 32'd1);
      cyc(); #1;
      chk("wrap3_wren_s2", 32'(wren3), 32'h4);
      chk("wrap3_pc", 32'(pc3), 32'd1);
      chk("wrap3_ram_low", 32'(ram3), 32'd0);
      cyc(); #1;
      chk("wrap3_instret", instret3, 32'd0);
      chk("wrap3_next_s0", 32'(wren3), 32'h1);

`ifdef STAGE_SEQUENCER_STEP_EN
      found = 0;
      for (int k = 0; k < 6 && found == 0; k++) begin
         cyc(); #1;
         if (cur5 == 3'd1) found = 1;
      end
      chk("step_find_s1", 32'(found), 32'd1);
      halt_req = 1'b1;
      cyc(); halt_req = 1'b0;
      found = 0;
      for (int k = 0; k < 12 && found == 0; k++) begin
         cyc(); #1;
         if (halted5) found = 1;
      end
      chk("step_halted", 32'(found), 32'd1);
      chk("step_pre_instret", instret5, 32'd3);
      step_req = 1'b1;
      cyc(); step_req = 1'b0;
      pulses = 0;
      for (int k = 0; k < 7; k++) begin
         #1;
         if (wren5 != '0) pulses++;
         cyc();
      end
      #1;
      chk("step_pulses", 32'(pulses), 32'd5);
      chk("step_instret", instret5, 32'd4);
      chk("step_back_halted", 32'(halted5), 32'd1);
      step_req = 1'b1; resume_req = 1'b1;
      cyc(); step_req = 1'b0; resume_req = 1'b0; #1;
      chk("step_resume_wren", 32'(wren5), 32'h01);
      repeat (5) cyc(); #1;
      chk("step_resume_run", 32'(halted5), 32'd0);
      chk("step_resume_instret", instret5, 32'd5);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
